// File: rtl/reg_file.sv
// 32 x 32-bit RISC-V integer register file: two combinational read ports, one clocked write port, x0 hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-through forwarding on both read ports.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    input  logic [ADDR_WIDTH-1:0] a3,
    input  logic                  we3,
    input  logic [DATA_WIDTH-1:0] wd3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  wr_en_s;

    // Writes to x0 are dropped; a3/wd3 only matter once we3 is high.
    assign wr_en_s = we3 && (a3 != ZERO_ADDR);

    // Next-state of the storage array: reset wins over a pending write.
    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_d[i] = ZERO_DATA;
            end
        end else if (wr_en_s) begin
            regs_d[a3] = wd3;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = ZERO_DATA;
    end

    // Storage register update.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read port 1 (ALU operand a).
    always_comb begin
        rd1 = ZERO_DATA;
        if (a1 == ZERO_ADDR) begin
            rd1 = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en_s && !rst && (a3 == a1)) begin
            rd1 = wd3;
`endif
        end else begin
            rd1 = regs_q[a1];
        end
    end

    // Read port 2 (ALU b-path and store data).
    always_comb begin
        rd2 = ZERO_DATA;
        if (a2 == ZERO_ADDR) begin
            rd2 = ZERO_DATA;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en_s && !rst && (a3 == a2)) begin
            rd2 = wd3;
`endif
        end else begin
            rd2 = regs_q[a2];
        end
    end

endmodule
